// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the RV32I core.
// Captures decoded operands/control, resolves EX/MEM and MEM/WB forwarding,
// detects load-use hazards (one-cycle stall plus bubble) and honours flushes.
// Optional build macro ID_EX_PERF_CNT_EN adds stall_count / flush_count outputs.
//
// Valid semantics: id_valid qualifies every id_* field in the same cycle;
// ex_valid qualifies every ex_* output. There is no ready: EX never
// backpressures, and stall_o is the only way this block holds upstream.
module id_ex_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     id_valid,
    input  logic [DATA_WIDTH-1:0]    id_pc,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [REG_ADDR_W-1:0]    id_rs1,
    input  logic [REG_ADDR_W-1:0]    id_rs2,
    input  logic [REG_ADDR_W-1:0]    id_rd,
    input  logic                     id_alu_src,
    input  logic [OPCODE_LENGTH-1:0] id_operation,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    input  logic                     id_mem_write,
    input  logic                     id_mem_to_reg,
    input  logic                     flush_i,
    input  logic                     exmem_reg_write,
    input  logic [REG_ADDR_W-1:0]    exmem_rd,
    input  logic [DATA_WIDTH-1:0]    exmem_result,
    input  logic                     memwb_reg_write,
    input  logic [REG_ADDR_W-1:0]    memwb_rd,
    input  logic [DATA_WIDTH-1:0]    memwb_result,
    output logic                     stall_o,
    output logic                     ex_valid,
    output logic [DATA_WIDTH-1:0]    ex_pc,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic [REG_ADDR_W-1:0]    ex_rd,
    output logic                     ex_reg_write,
    output logic                     ex_mem_read,
    output logic                     ex_mem_write,
    output logic                     ex_mem_to_reg
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]              stall_count,
    output logic [31:0]              flush_count
`endif
);

    // Contents of the EX stage; a bubble is the all-zero value.
    typedef struct packed {
        logic                     valid;
        logic [DATA_WIDTH-1:0]    pc;
        logic [DATA_WIDTH-1:0]    rs1_data;
        logic [DATA_WIDTH-1:0]    rs2_data;
        logic [DATA_WIDTH-1:0]    imm;
        logic [REG_ADDR_W-1:0]    rs1;
        logic [REG_ADDR_W-1:0]    rs2;
        logic [REG_ADDR_W-1:0]    rd;
        logic                     alu_src;
        logic [OPCODE_LENGTH-1:0] operation;
        logic                     reg_write;
        logic                     mem_read;
        logic                     mem_write;
        logic                     mem_to_reg;
    } ex_reg_t;

    ex_reg_t ex_q;
    ex_reg_t ex_d;
    logic    load_use;
    logic    bubble;
    logic [DATA_WIDTH-1:0] fwd_a;
    logic [DATA_WIDTH-1:0] fwd_b;

    // Forward the youngest in-flight writer of idx; x0 is never forwarded.
    function automatic logic [DATA_WIDTH-1:0] forward(
        input logic [REG_ADDR_W-1:0] idx,
        input logic [DATA_WIDTH-1:0] reg_val
    );
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == idx))
            return exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == idx))
            return memwb_result;
        else
            return reg_val;
    endfunction

    // A load in EX whose rd feeds the instruction in ID must wait one cycle.
    always_comb begin
        load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & id_valid &
                   ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
        stall_o  = load_use & ~flush_i;
        bubble   = flush_i | stall_o;
    end

    // Next EX contents: a bubble on flush or stall, otherwise the decoded instruction.
    always_comb begin
        ex_d = '0;
        if (!bubble) begin
            ex_d.valid      = id_valid;
            ex_d.pc         = id_pc;
            ex_d.rs1_data   = id_rs1_data;
            ex_d.rs2_data   = id_rs2_data;
            ex_d.imm        = id_imm;
            ex_d.rs1        = id_rs1;
            ex_d.rs2        = id_rs2;
            ex_d.rd         = id_rd;
            ex_d.alu_src    = id_alu_src;
            ex_d.operation  = id_operation;
            ex_d.reg_write  = id_reg_write;
            ex_d.mem_read   = id_mem_read;
            ex_d.mem_write  = id_mem_write;
            ex_d.mem_to_reg = id_mem_to_reg;
        end
    end

    // Pipeline register; reset drops EX contents immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    // Zero-latency operand forwarding and ALU source selection.
    always_comb begin
        fwd_a         = forward(ex_q.rs1, ex_q.rs1_data);
        fwd_b         = forward(ex_q.rs2, ex_q.rs2_data);
        SrcA          = fwd_a;
        SrcB          = ex_q.alu_src ? ex_q.imm : fwd_b;
        ex_store_data = fwd_b;
    end

    assign ex_valid      = ex_q.valid;
    assign ex_pc         = ex_q.pc;
    assign Operation     = ex_q.operation;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.reg_write  & ex_q.valid;
    assign ex_mem_read   = ex_q.mem_read   & ex_q.valid;
    assign ex_mem_write  = ex_q.mem_write  & ex_q.valid;
    assign ex_mem_to_reg = ex_q.mem_to_reg & ex_q.valid;

`ifdef ID_EX_PERF_CNT_EN
    // Event counters; flushes count only when they squash a real instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_o)
                stall_count <= stall_count + 32'd1;
            if (flush_i && (id_valid || ex_q.valid))
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table plus randomized run against a
// behavioural model of the ID/EX stage.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int OL = 4;
    localparam int RW = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          id_valid;
    logic [DW-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_alu_src;
    logic [OL-1:0] id_operation;
    logic          id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic          flush_i;
    logic          exmem_reg_write, memwb_reg_write;
    logic [RW-1:0] exmem_rd, memwb_rd;
    logic [DW-1:0] exmem_result, memwb_result;
    logic          stall_o, ex_valid;
    logic [DW-1:0] ex_pc, SrcA, SrcB, ex_store_data;
    logic [OL-1:0] Operation;
    logic [RW-1:0] ex_rd;
    logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]   stall_count, flush_count;
`endif

    id_ex_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL), .REG_ADDR_W(RW)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_src(id_alu_src), .id_operation(id_operation),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .flush_i(flush_i),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .stall_o(stall_o), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
`ifdef ID_EX_PERF_CNT_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    // ---------------- stimulus records ----------------
    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc, rs1_data, rs2_data, imm;
        logic [RW-1:0] rs1, rs2, rd;
        logic          alu_src;
        logic [OL-1:0] op;
        logic          rw, mr, mw, m2r;
    } id_t;

    typedef struct packed {
        logic          exm_w;
        logic [RW-1:0] exm_rd;
        logic [DW-1:0] exm_res;
        logic          mwb_w;
        logic [RW-1:0] mwb_rd;
        logic [DW-1:0] mwb_res;
    } fwd_t;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] srca, srcb, store;
        logic [OL-1:0] op;
        logic          stall, rw, mr;
    } exp_t;

    typedef struct packed {
        id_t  id;
        fwd_t fwd;
        logic flush;
        exp_t exp;
    } tvec_t;

    function automatic id_t mk_id(input logic v, input logic [DW-1:0] pc,
                                  input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                                  input logic [RW-1:0] rd, input logic [DW-1:0] d1,
                                  input logic [DW-1:0] d2, input logic [DW-1:0] imm,
                                  input logic alu_src, input logic [OL-1:0] op,
                                  input logic rw, input logic mr);
        id_t r;
        r = '0;
        r.valid = v; r.pc = pc; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
        r.rs1_data = d1; r.rs2_data = d2; r.imm = imm; r.alu_src = alu_src;
        r.op = op; r.rw = rw; r.mr = mr; r.mw = 1'b0; r.m2r = mr;
        return r;
    endfunction

    function automatic fwd_t mk_fwd(input logic ew, input logic [RW-1:0] erd, input logic [DW-1:0] eres,
                                    input logic mw, input logic [RW-1:0] mrd, input logic [DW-1:0] mres);
        fwd_t f;
        f.exm_w = ew; f.exm_rd = erd; f.exm_res = eres;
        f.mwb_w = mw; f.mwb_rd = mrd; f.mwb_res = mres;
        return f;
    endfunction

    function automatic exp_t mk_exp(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input logic [DW-1:0] st, input logic [OL-1:0] op,
                                    input logic stall, input logic rw, input logic mr);
        exp_t e;
        e.valid = v; e.srca = a; e.srcb = b; e.store = st; e.op = op;
        e.stall = stall; e.rw = rw; e.mr = mr;
        return e;
    endfunction

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_ex is whatever instruction the EX stage should hold; '0 is a bubble.
    id_t         m_ex;
    logic [31:0] m_stall_cnt, m_flush_cnt;

    function automatic id_t cur_id();
        id_t r;
        r.valid = id_valid; r.pc = id_pc; r.rs1_data = id_rs1_data; r.rs2_data = id_rs2_data;
        r.imm = id_imm; r.rs1 = id_rs1; r.rs2 = id_rs2; r.rd = id_rd; r.alu_src = id_alu_src;
        r.op = id_operation; r.rw = id_reg_write; r.mr = id_mem_read; r.mw = id_mem_write;
        r.m2r = id_mem_to_reg;
        return r;
    endfunction

    function automatic logic [DW-1:0] m_fwd(input logic [RW-1:0] idx, input logic [DW-1:0] v);
        if (exmem_reg_write && exmem_rd != 0 && exmem_rd == idx) return exmem_result;
        if (memwb_reg_write && memwb_rd != 0 && memwb_rd == idx) return memwb_result;
        return v;
    endfunction

    function automatic logic m_stall();
        return m_ex.valid && m_ex.mr && m_ex.rd != 0 && id_valid &&
               (m_ex.rd == id_rs1 || m_ex.rd == id_rs2) && !flush_i;
    endfunction

    task automatic check_model();
        logic [DW-1:0] fb;
        fb = m_fwd(m_ex.rs2, m_ex.rs2_data);
        chk("m_stall", stall_o, m_stall());
        chk("m_ex_valid", ex_valid, m_ex.valid);
        chk("m_reg_write", ex_reg_write, m_ex.valid & m_ex.rw);
        chk("m_mem_read", ex_mem_read, m_ex.valid & m_ex.mr);
        chk("m_mem_write", ex_mem_write, m_ex.valid & m_ex.mw);
        chk("m_mem_to_reg", ex_mem_to_reg, m_ex.valid & m_ex.m2r);
        if (m_ex.valid) begin
            chk("m_srca", SrcA, m_fwd(m_ex.rs1, m_ex.rs1_data));
            chk("m_srcb", SrcB, m_ex.alu_src ? m_ex.imm : fb);
            chk("m_store", ex_store_data, fb);
            chk("m_op", Operation, m_ex.op);
            chk("m_rd", ex_rd, m_ex.rd);
            chk("m_pc", ex_pc, m_ex.pc);
        end
    endtask

    // Advance one clock: the model applies the flush/stall/capture rules.
    task automatic tick();
        logic s;
        id_t  nxt;
        s = m_stall();
        if (s) m_stall_cnt++;
        if (flush_i && (id_valid || m_ex.valid)) m_flush_cnt++;
        nxt = (flush_i || s) ? id_t'('0) : cur_id();
        @(posedge clk);
        m_ex = nxt;
        #1;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input id_t i, input fwd_t f, input logic fl);
        id_valid = i.valid; id_pc = i.pc; id_rs1_data = i.rs1_data; id_rs2_data = i.rs2_data;
        id_imm = i.imm; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd; id_alu_src = i.alu_src;
        id_operation = i.op; id_reg_write = i.rw; id_mem_read = i.mr; id_mem_write = i.mw;
        id_mem_to_reg = i.m2r;
        exmem_reg_write = f.exm_w; exmem_rd = f.exm_rd; exmem_result = f.exm_res;
        memwb_reg_write = f.mwb_w; memwb_rd = f.mwb_rd; memwb_result = f.mwb_res;
        flush_i = fl;
    endtask

    task automatic check_counters(input string tag);
`ifdef ID_EX_PERF_CNT_EN
        chk({tag, "_stall_count"}, stall_count, m_stall_cnt);
        chk({tag, "_flush_count"}, flush_count, m_flush_cnt);
`else
        chk({tag, "_stall_seen"}, stall_o, 1'b0);
`endif
    endtask

    // ---------------- test ----------------
    tvec_t tbl[10];
    id_t   i0, i1, lw, add, nop, rid;
    fwd_t  f_none, f_both, f_mwb, f_rd0, f_m4, rf;
    logic  held;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] sc0, fc0;
`endif

    initial begin
        //                 v  pc        rs1 rs2 rd d1         d2        imm       alu op    rw mr
        i0  = mk_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd6, 32'h5,   32'h9,  32'h7,  1'b1, 4'h2, 1'b1, 1'b0);
        i1  = mk_id(1'b1, 32'h104, 5'd3, 5'd3, 5'd7, 32'h11,  32'h22, 32'h40, 1'b0, 4'h6, 1'b1, 1'b0);
        lw  = mk_id(1'b1, 32'h108, 5'd1, 5'd0, 5'd4, 32'h100, 32'h0,  32'h8,  1'b1, 4'h0, 1'b1, 1'b1);
        add = mk_id(1'b1, 32'h10c, 5'd4, 5'd1, 5'd5, 32'h33,  32'h10, 32'h0,  1'b0, 4'h0, 1'b1, 1'b0);
        nop = '0;
        f_none = '0;
        f_both = mk_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        f_mwb  = mk_fwd(1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        f_rd0  = mk_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
        f_m4   = mk_fwd(1'b0, 5'd0, 32'h0,  1'b1, 5'd4, 32'hBB);

        // Each row's expectation is what EX shows while that row's inputs are driven.
        tbl[0] = '{id: i0,  fwd: f_none, flush: 1'b0, exp: mk_exp(1'b0, 0, 0, 0, 4'h0, 1'b0, 1'b0, 1'b0)};
        tbl[1] = '{id: i1,  fwd: f_none, flush: 1'b0, exp: mk_exp(1'b1, 32'h5, 32'h7, 32'h9, 4'h2, 1'b0, 1'b1, 1'b0)};
        tbl[2] = '{id: i1,  fwd: f_both, flush: 1'b0, exp: mk_exp(1'b1, 32'hAA, 32'hAA, 32'hAA, 4'h6, 1'b0, 1'b1, 1'b0)};
        tbl[3] = '{id: i1,  fwd: f_mwb,  flush: 1'b0, exp: mk_exp(1'b1, 32'hBB, 32'hBB, 32'hBB, 4'h6, 1'b0, 1'b1, 1'b0)};
        tbl[4] = '{id: lw,  fwd: f_rd0,  flush: 1'b0, exp: mk_exp(1'b1, 32'h11, 32'h22, 32'h22, 4'h6, 1'b0, 1'b1, 1'b0)};
        tbl[5] = '{id: add, fwd: f_none, flush: 1'b0, exp: mk_exp(1'b1, 32'h100, 32'h8, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1)};
        tbl[6] = '{id: add, fwd: f_none, flush: 1'b0, exp: mk_exp(1'b0, 0, 0, 0, 4'h0, 1'b0, 1'b0, 1'b0)};
        tbl[7] = '{id: lw,  fwd: f_m4,   flush: 1'b0, exp: mk_exp(1'b1, 32'hBB, 32'h10, 32'h10, 4'h0, 1'b0, 1'b1, 1'b0)};
        tbl[8] = '{id: add, fwd: f_none, flush: 1'b1, exp: mk_exp(1'b1, 32'h100, 32'h8, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1)};
        tbl[9] = '{id: nop, fwd: f_none, flush: 1'b0, exp: mk_exp(1'b0, 0, 0, 0, 4'h0, 1'b0, 1'b0, 1'b0)};

        // Power-on reset
        drive(nop, f_none, 1'b0);
        m_ex = '0; m_stall_cnt = '0; m_flush_cnt = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #3;
        chk("rst_ex_valid", ex_valid, 1'b0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_srca", SrcA, 32'h0);
        chk("rst_op", Operation, 4'h0);
        chk("rst_reg_write", ex_reg_write, 1'b0);
        check_counters("rst");
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].id, tbl[i].fwd, tbl[i].flush);
            #3;
            chk("tbl_ex_valid", ex_valid, tbl[i].exp.valid);
            chk("tbl_stall", stall_o, tbl[i].exp.stall);
            chk("tbl_reg_write", ex_reg_write, tbl[i].exp.rw);
            chk("tbl_mem_read", ex_mem_read, tbl[i].exp.mr);
            if (tbl[i].exp.valid) begin
                chk("tbl_srca", SrcA, tbl[i].exp.srca);
                chk("tbl_srcb", SrcB, tbl[i].exp.srcb);
                chk("tbl_store", ex_store_data, tbl[i].exp.store);
                chk("tbl_op", Operation, tbl[i].exp.op);
            end
            check_model();
`ifdef ID_EX_PERF_CNT_EN
            sc0 = stall_count; fc0 = flush_count;
`endif
            tick();
`ifdef ID_EX_PERF_CNT_EN
            if (tbl[i].flush) begin
                chk("flush_cnt_step", flush_count, fc0 + 32'd1);
                chk("flush_stall_cnt_hold", stall_count, sc0);
            end
`endif
        end
        check_counters("tbl");

        // Randomized run; upstream re-presents the same instruction after a stall.
        held = 1'b0;
        rid = '0;
        for (int c = 0; c < 400; c++) begin
            if (!held) begin
                rid.valid = ($urandom_range(0, 7) != 0);
                rid.pc = $urandom; rid.rs1_data = $urandom; rid.rs2_data = $urandom;
                rid.imm = $urandom;
                rid.rs1 = 5'($urandom_range(0, 3)); rid.rs2 = 5'($urandom_range(0, 3));
                rid.rd = 5'($urandom_range(0, 3));
                rid.alu_src = 1'($urandom_range(0, 1)); rid.op = 4'($urandom_range(0, 15));
                rid.rw = 1'($urandom_range(0, 1)); rid.mr = ($urandom_range(0, 2) == 0);
                rid.mw = 1'($urandom_range(0, 1)); rid.m2r = 1'($urandom_range(0, 1));
            end
            rf = mk_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                        1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
            drive(rid, rf, ($urandom_range(0, 7) == 0));
            #3;
            check_model();
            held = m_stall();
            tick();
        end
        check_counters("rand");

        // Mid-stream reset: load in EX with a dependent instruction in ID.
        drive(lw, f_none, 1'b0);
        tick();
        drive(add, f_none, 1'b0);
        #3;
        chk("pre_rst_stall", stall_o, 1'b1);
        chk("pre_rst_valid", ex_valid, 1'b1);
        #1 reset_n = 1'b0;
        m_ex = '0; m_stall_cnt = '0; m_flush_cnt = '0;
        #1;
        chk("mid_rst_ex_valid", ex_valid, 1'b0);
        chk("mid_rst_stall", stall_o, 1'b0);
        chk("mid_rst_srca", SrcA, 32'h0);
        chk("mid_rst_mem_read", ex_mem_read, 1'b0);
        chk("mid_rst_reg_write", ex_reg_write, 1'b0);
        check_counters("mid_rst");
        @(posedge clk);
        #1 reset_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the RV32I core. Captures decoded operands and control each cycle and presents forwarded SrcA/SrcB plus Operation to the ALU.
- Also resolves EX/MEM and MEM/WB data forwarding.
- Detects load-use hazards, raising a one-cycle stall and inserting a bubble.
- Honours a flush from branch/jump resolution.

Parameters:
- DATA_WIDTH, 32, datapath width.
- OPCODE_LENGTH, 4, width of the ALU Operation code.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_pc  in  DATA_WIDTH  PC of the decoded instruction.
- id_rs1_data  in  DATA_WIDTH  register file read port 1.
- id_rs2_data  in  DATA_WIDTH  register file read port 2.
- id_imm  in  DATA_WIDTH  sign-extended immediate.
- id_rs1  in  REG_ADDR_W  source register 1 index.
- id_rs2  in  REG_ADDR_W  source register 2 index.
- id_rd  in  REG_ADDR_W  destination register index.
- id_alu_src  in  1  1 = SrcB takes the immediate.
- id_operation  in  OPCODE_LENGTH  ALU operation code.
- id_reg_write  in  1  control bit.
- id_mem_read  in  1  control bit.
- id_mem_write  in  1  control bit.
- id_mem_to_reg  in  1  control bit.
- flush_i  in  1  squash the instruction entering EX.
- exmem_reg_write  in  1  EX/MEM writes a register.
- exmem_rd  in  REG_ADDR_W  EX/MEM destination register.
- exmem_result  in  DATA_WIDTH  EX/MEM ALU result.
- memwb_reg_write  in  1  MEM/WB writes a register.
- memwb_rd  in  REG_ADDR_W  MEM/WB destination register.
- memwb_result  in  DATA_WIDTH  MEM/WB write-back data.
- stall_o  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc  out  DATA_WIDTH  registered PC.
- SrcA  out  DATA_WIDTH  ALU operand A.
- SrcB  out  DATA_WIDTH  ALU operand B.
- Operation  out  OPCODE_LENGTH  ALU operation code.
- ex_store_data  out  DATA_WIDTH  forwarded rs2 value for stores.
- ex_rd  out  REG_ADDR_W  registered destination register.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  control bits, gated by ex_valid.

Behaviour:
- Reset (async, reset_n=0): all registered fields 0, ex_valid=0, Operation=4'b0000. All control outputs read 0, so EX holds a bubble. Reset mid-operation discards EX contents immediately.
- Hazard detect, combinational:
  - load_use = ex_valid & ex_mem_read_reg & (ex_rd!=0) & id_valid & ((ex_rd==id_rs1) | (ex_rd==id_rs2)).
  - stall_o = load_use & ~flush_i.
- Register update at each rising clk, in priority order:
  - flush_i=1: load a bubble (ex_valid=0, all control 0). Flush beats stall.
  - stall_o=1: load a bubble. Upstream holds, so the same instruction is re-presented next cycle. The stall therefore lasts exactly 1 cycle, because the load has moved to MEM.
  - Otherwise: capture all id_* fields, with ex_valid=id_valid.
- No enable and no hold state: a bubble always advances.
- Forwarding for operand A, combinational on the registered ex_rs1:
  - If exmem_reg_write & exmem_rd!=0 & exmem_rd==ex_rs1, use exmem_result.
  - Else if memwb_reg_write & memwb_rd!=0 & memwb_rd==ex_rs1, use memwb_result.
  - Else use the registered rs1 data.
  - EX/MEM has priority over MEM/WB.
- Forwarding for operand B (fwdB): identical rule on ex_rs2.
- SrcA = fwdA.
- SrcB = ex_alu_src ? ex_imm : fwdB.
- ex_store_data = fwdB, always, independent of alu_src.
- Register x0 is never forwarded.
- Operand path latency: 1 cycle from id_* to SrcA/SrcB. The forwarding path is zero latency.
- Control outputs: each is its registered bit AND ex_valid.
- The ALU is purely combinational; no backpressure from EX.
- Same-cycle register file write/read bypass belongs to the register file, not this block.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: adds outputs stall_count and flush_count, each 32 bits, reset to 0.
  - stall_count increments on each cycle with stall_o=1.
  - flush_count increments on each cycle with flush_i=1 while a valid instruction is being squashed (id_valid | ex_valid).
  - Both counters wrap modulo 2^32.
- Undefined: neither the ports nor the counter logic exist; all other behaviour is identical.

Test Plan:
- Reset: assert reset_n=0 mid-stream -> ex_valid=0, all controls 0, SrcA=0, stall_o=0, with no clock edge required.
- Plain capture: id_rs1_data=5, id_imm=7, alu_src=1, Operation=0010 -> next cycle SrcA=5, SrcB=7, Operation=0010, ex_valid=1.
- Forwarding priority: ex_rs1=3, exmem_rd=3 (result 0xAA), memwb_rd=3 (result 0xBB), both writing -> SrcA=0xAA. Deassert exmem_reg_write -> SrcA=0xBB. Set rd=0 on both -> no forward.
- Load-use: lw x4 in EX, add x5,x4,x1 in ID -> stall_o=1 for exactly 1 cycle and a bubble enters EX. The add then enters EX and receives 0xBB via the MEM/WB forward when memwb_rd=4.
- Flush during stall: load_use condition true and flush_i=1 -> stall_o=0 and EX becomes a bubble. With ID_EX_PERF_CNT_EN, flush_count increments by 1 and stall_count is unchanged.
